// File: rtl/traffic_ctrl_multi.sv
// N-approach intersection controller.
// Serves green round-robin across NUM_DIR approaches, each followed by yellow
// and an all-red clearance. A latched pedestrian request is served in a
// dedicated WALK phase (all approaches red) taken from all-red. A pending
// request can end green early once the minimum green time has elapsed.
// Phase timing counts tick_en strobes, not clocks.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   tick_en    one-clk timebase strobe; phase counter advances only when high
//   ped_req    pedestrian request (level or pulse), sampled every clk
//   red        per-approach red lamp
//   yellow     per-approach yellow lamp
//   green      per-approach green lamp
//   walk       pedestrian walk lamp
//   ped_ack    one-clk pulse on entry to WALK
//   state      phase: 0 ALLRED, 1 GREEN, 2 YELLOW, 3 WALK
//   active_dir approach currently (or next) served
module traffic_ctrl_multi #(
  parameter int unsigned NUM_DIR         = 4,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned GREEN_TICKS     = 20,
  parameter int unsigned YELLOW_TICKS    = 4,
  parameter int unsigned ALLRED_TICKS    = 2,
  parameter int unsigned WALK_TICKS      = 10,
  parameter int unsigned MIN_GREEN_TICKS = 5,
  parameter int unsigned DIR_W           = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_en,
  input  logic               ped_req,
  output logic [NUM_DIR-1:0] red,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] green,
  output logic               walk,
  output logic               ped_ack,
  output logic [1:0]         state,
  output logic [DIR_W-1:0]   active_dir
);

  typedef enum logic [1:0] {
    StAllRed = 2'd0,
    StGreen  = 2'd1,
    StYellow = 2'd2,
    StWalk   = 2'd3
  } phase_e;

  localparam logic [CNT_W-1:0] GreenLast    = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YellowLast   = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] AllRedLast   = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] WalkLast     = CNT_W'(WALK_TICKS - 1);
  localparam logic [CNT_W-1:0] MinGreenLast = CNT_W'(MIN_GREEN_TICKS - 1);
  localparam logic [DIR_W-1:0] DirLast      = DIR_W'(NUM_DIR - 1);

  phase_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic               pend_q, pend_d;
  // Set through WALK; held until ped_req is seen low so a held request
  // cannot re-arm itself after being served.
  logic               block_q, block_d;
  logic [CNT_W-1:0]   phase_last;
  logic               done;
  logic               enter_walk;
  logic [NUM_DIR-1:0] red_d, yellow_d, green_d;

  always_comb begin
    unique case (state_q)
      StAllRed: phase_last = AllRedLast;
      StGreen:  phase_last = GreenLast;
      StYellow: phase_last = YellowLast;
      StWalk:   phase_last = WalkLast;
    endcase
  end

  assign done = tick_en && (cnt_q == phase_last);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    unique case (state_q)
      StAllRed: if (done) state_d = pend_q ? StWalk : StGreen;
      // Full green and early exit collapse into the same single transition.
      StGreen:  if (done || (tick_en && pend_q && (cnt_q >= MinGreenLast))) state_d = StYellow;
      StYellow: begin
        if (done) begin
          state_d = StAllRed;
          dir_d   = (dir_q == DirLast) ? '0 : dir_q + 1'b1;
        end
      end
      StWalk:   if (done) state_d = StAllRed;
    endcase
  end

  assign enter_walk = (state_d == StWalk) && (state_q != StWalk);

  always_comb begin
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    block_d = block_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (tick_en) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (enter_walk) begin
      pend_d = 1'b0;
    end else if (ped_req && (state_q != StWalk) && !block_q) begin
      pend_d = 1'b1;
    end
    if ((state_q == StWalk) || enter_walk) begin
      block_d = 1'b1;
    end else if (!ped_req) begin
      block_d = 1'b0;
    end
  end

  // Lamps decoded from next state so they change on the same edge as state.
  always_comb begin
    red_d    = '1;
    yellow_d = '0;
    green_d  = '0;
    unique case (state_d)
      StGreen: begin
        red_d[dir_d]   = 1'b0;
        green_d[dir_d] = 1'b1;
      end
      StYellow: begin
        red_d[dir_d]    = 1'b0;
        yellow_d[dir_d] = 1'b1;
      end
      StAllRed, StWalk: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAllRed;
      cnt_q   <= '0;
      dir_q   <= '0;
      pend_q  <= 1'b0;
      block_q <= 1'b0;
      red     <= '1;
      yellow  <= '0;
      green   <= '0;
      walk    <= 1'b0;
      ped_ack <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      block_q <= block_d;
      red     <= red_d;
      yellow  <= yellow_d;
      green   <= green_d;
      walk    <= (state_d == StWalk);
      ped_ack <= enter_walk;
    end
  end

  assign state      = state_q;
  assign active_dir = dir_q;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
module tb_traffic_ctrl_multi;

  localparam logic [1:0] AR = 2'd0;
  localparam logic [1:0] GR = 2'd1;
  localparam logic [1:0] YE = 2'd2;
  localparam logic [1:0] WK = 2'd3;

  typedef struct packed {
    logic [1:0] st;
    logic [2:0] dir;
    logic       ack;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_en = 1'b1;
  logic ped_req = 1'b0;

  logic [2:0] red3, yellow3, green3;
  logic       walk3, ack3;
  logic [1:0] state3;
  logic [1:0] dir3;

  logic [4:0] red5, yellow5, green5;
  logic       walk5, ack5;
  logic [1:0] state5;
  logic [2:0] dir5;

  exp_t sb3[$];
  exp_t sb5[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  traffic_ctrl_multi #(
    .NUM_DIR(3), .CNT_W(8), .GREEN_TICKS(5), .YELLOW_TICKS(2),
    .ALLRED_TICKS(1), .WALK_TICKS(4), .MIN_GREEN_TICKS(2)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .ped_req(ped_req),
    .red(red3), .yellow(yellow3), .green(green3), .walk(walk3),
    .ped_ack(ack3), .state(state3), .active_dir(dir3)
  );

  traffic_ctrl_multi #(
    .NUM_DIR(5), .CNT_W(8), .GREEN_TICKS(5), .YELLOW_TICKS(2),
    .ALLRED_TICKS(1), .WALK_TICKS(4), .MIN_GREEN_TICKS(2)
  ) dut5 (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .ped_req(ped_req),
    .red(red5), .yellow(yellow5), .green(green5), .walk(walk5),
    .ped_ack(ack5), .state(state5), .active_dir(dir5)
  );

  // Monitors: one expected snapshot per falling edge while entries are queued.
  always @(negedge clk) begin
    if (sb3.size() > 0) begin
      exp_t e;
      logic [2:0] eg, ey, er;
      e  = sb3.pop_front();
      eg = (e.st == GR) ? 3'(1 << e.dir) : 3'b000;
      ey = (e.st == YE) ? 3'(1 << e.dir) : 3'b000;
      er = ~(eg | ey);
      n_checks++;
      if ({state3, dir3, red3, yellow3, green3, walk3, ack3} !==
          {e.st, e.dir[1:0], er, ey, eg, (e.st == WK), e.ack}) begin
        n_fail++;
        $display("FAIL dut3 t=%0t st/dir/r/y/g/walk/ack got %0d %0d %b %b %b %b %b exp %0d %0d %b %b %b %b %b",
                 $time, state3, dir3, red3, yellow3, green3, walk3, ack3,
                 e.st, e.dir, er, ey, eg, (e.st == WK), e.ack);
      end
    end
  end

  always @(negedge clk) begin
    if (sb5.size() > 0) begin
      exp_t e;
      logic [4:0] eg, ey, er;
      e  = sb5.pop_front();
      eg = (e.st == GR) ? 5'(1 << e.dir) : 5'b00000;
      ey = (e.st == YE) ? 5'(1 << e.dir) : 5'b00000;
      er = ~(eg | ey);
      n_checks++;
      if ({state5, dir5, red5, yellow5, green5, walk5, ack5} !==
          {e.st, e.dir, er, ey, eg, (e.st == WK), e.ack}) begin
        n_fail++;
        $display("FAIL dut5 t=%0t st/dir/r/y/g/walk/ack got %0d %0d %b %b %b %b %b exp %0d %0d %b %b %b %b %b",
                 $time, state5, dir5, red5, yellow5, green5, walk5, ack5,
                 e.st, e.dir, er, ey, eg, (e.st == WK), e.ack);
      end
    end
  end

  task automatic push(input bit five, input logic [1:0] st, input int dir, input int n,
                      input bit ack);
    exp_t e;
    e.st  = st;
    e.dir = 3'(dir);
    e.ack = ack;
    repeat (n) begin
      if (five) sb5.push_back(e);
      else sb3.push_back(e);
    end
  endtask

  // Reset-release snapshot, then `rounds` full green/yellow/all-red cycles.
  task automatic push_rounds(input bit five, input int ndir, input int rounds);
    push(five, AR, 0, 1, 1'b0);
    for (int i = 0; i < rounds; i++) begin
      push(five, GR, i % ndir, 5, 1'b0);
      push(five, YE, i % ndir, 2, 1'b0);
      push(five, AR, (i + 1) % ndir, 1, 1'b0);
    end
    push(five, GR, rounds % ndir, 1, 1'b0);
  endtask

  // Leaves rst_n low at posedge+1; caller queues expectations then releases.
  task automatic hold_reset();
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    ped_req = 1'b0;
    tick_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while ((sb3.size() > 0 || sb5.size() > 0) && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    if (sb3.size() > 0 || sb5.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout left3=%0d left5=%0d required 0 0", sb3.size(), sb5.size());
      sb3.delete();
      sb5.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Free-running round robin, 3 and 5 approaches side by side.
    hold_reset();
    push_rounds(1'b0, 3, 5);
    push_rounds(1'b1, 5, 5);
    rst_n = 1'b1;
    drain(200);

    // Single-clk request on first clk of dir1 green: short green, then WALK.
    hold_reset();
    push(0, AR, 0, 1, 0); push(0, GR, 0, 5, 0); push(0, YE, 0, 2, 0);
    push(0, AR, 1, 1, 0); push(0, GR, 1, 2, 0); push(0, YE, 1, 2, 0);
    push(0, AR, 2, 1, 0); push(0, WK, 2, 1, 1); push(0, WK, 2, 3, 0);
    push(0, AR, 2, 1, 0); push(0, GR, 2, 1, 0);
    rst_n = 1'b1;
    repeat (9) @(posedge clk);
    #1 ped_req = 1'b1;
    @(posedge clk);
    #1 ped_req = 1'b0;
    drain(200);

    // Request held 20 clk: one WALK only; re-arms after drop and reassert.
    hold_reset();
    push(0, AR, 0, 1, 0); push(0, GR, 0, 2, 0); push(0, YE, 0, 2, 0);
    push(0, AR, 1, 1, 0); push(0, WK, 1, 1, 1); push(0, WK, 1, 3, 0);
    push(0, AR, 1, 1, 0); push(0, GR, 1, 5, 0); push(0, YE, 1, 2, 0);
    push(0, AR, 2, 1, 0); push(0, GR, 2, 5, 0); push(0, YE, 2, 2, 0);
    push(0, AR, 0, 1, 0); push(0, GR, 0, 2, 0); push(0, YE, 0, 2, 0);
    push(0, AR, 1, 1, 0); push(0, WK, 1, 1, 1); push(0, WK, 1, 3, 0);
    push(0, AR, 1, 1, 0); push(0, GR, 1, 1, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 ped_req = 1'b1;
    repeat (20) @(posedge clk);
    #1 ped_req = 1'b0;
    repeat (6) @(posedge clk);
    #1 ped_req = 1'b1;
    @(posedge clk);
    #1 ped_req = 1'b0;
    drain(200);

    // Timebase one clk in four: every phase stretches 4x.
    hold_reset();
    push(0, AR, 0, 5, 0); push(0, GR, 0, 20, 0); push(0, YE, 0, 8, 0);
    push(0, AR, 1, 4, 0); push(0, GR, 1, 4, 0);
    tick_en = 1'b0;
    rst_n   = 1'b1;
    for (int i = 1; i <= 41; i++) begin
      @(posedge clk);
      #1 tick_en = (i % 4 == 0);
    end
    tick_en = 1'b1;
    drain(200);

    // Reset mid-yellow of dir1 with a request pending: discarded entirely.
    hold_reset();
    push(0, AR, 0, 1, 0); push(0, GR, 0, 5, 0); push(0, YE, 0, 2, 0);
    push(0, AR, 1, 1, 0); push(0, GR, 1, 2, 0);
    push(0, AR, 0, 2, 0);
    push(0, GR, 0, 5, 0); push(0, YE, 0, 2, 0); push(0, AR, 1, 1, 0);
    push(0, GR, 1, 1, 0);
    rst_n = 1'b1;
    repeat (9) @(posedge clk);
    #1 ped_req = 1'b1;
    @(posedge clk);
    #1 ped_req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
